md_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO result registers, sitting in the E stage of the five-stage pipeline beside the ALU. Accepts one operation per start pulse, holds `busy` for a configurable latency so the hazard controller can stall later HI/LO users, then commits results to HI/LO. Generalises the single-cycle ALU path to `WIDTH`-bit operands with independent multiply and divide latencies, signed and unsigned modes, and direct HI/LO writes.

---
 rtl/md_pkg.sv | 25 ++
 rtl/md_arith.sv | 73 +++++++
 rtl/md_unit.sv | 133 +++++++++++++
 tb/tb_md_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: op codes and FSM state type.
package md_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Codes 0..3 are the multi-cycle multiply/divide operations.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational signed/unsigned multiply and divide.
// Ports:
//   op_i        operation code (only MULT/MULTU/DIV/DIVU are meaningful)
//   a_i, b_i    operands
//   res_hi_c    product upper half, or remainder
//   res_lo_c    product lower half, or quotient
//   div_zero_c  divide op with a zero divisor (result must not be committed)
module md_arith
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_hi_c,
    output logic [WIDTH-1:0] res_lo_c,
    output logic             div_zero_c
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic             is_signed;
    logic             is_mul;
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    logic [PW-1:0]    prod;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_div;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    // Sign-extend to 2*WIDTH so a plain unsigned multiply yields the signed product.
    always_comb begin
        is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
        is_mul    = is_mul_op(op_i);
        a_ext     = is_signed ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
        b_ext     = is_signed ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
        prod      = a_ext * b_ext;
    end

    // Divide on magnitudes; most-negative magnitude stays representable as unsigned,
    // so most-negative / -1 wraps back to most-negative with zero remainder.
    always_comb begin
        a_neg      = is_signed & a_i[WIDTH-1];
        b_neg      = is_signed & b_i[WIDTH-1];
        a_mag      = a_neg ? (ZERO - a_i) : a_i;
        b_mag      = b_neg ? (ZERO - b_i) : b_i;
        div_zero_c = !is_mul && (b_i == ZERO);
        b_div      = (b_i == ZERO) ? ONE : b_mag;
        q_mag      = a_mag / b_div;
        r_mag      = a_mag % b_div;
        quot       = (a_neg ^ b_neg) ? (ZERO - q_mag) : q_mag;
        rem        = a_neg ? (ZERO - r_mag) : r_mag;
    end

    always_comb begin
        res_hi_c = rem;
        res_lo_c = quot;
        if (is_mul) begin
            res_hi_c = prod[PW-1:WIDTH];
            res_lo_c = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   start, op    issue strobe and operation code
//   a, b         rs / rt operands, sampled only on an accepted start
//   busy         operation in flight (through the commit cycle)
//   done         one-cycle pulse on multiply/divide commit
//   hi, lo       HI/LO architectural registers
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic             keep_q, keep_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] arith_hi;
    logic [WIDTH-1:0] arith_lo;
    logic             arith_dz;

    md_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .res_hi_c   (arith_hi),
        .res_lo_c   (arith_lo),
        .div_zero_c (arith_dz)
    );

    // Next-state: issue in IDLE, count down in RUN, commit when the counter reaches 1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        keep_d   = keep_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_md_op(op)) begin
                        state_d  = ST_RUN;
                        cnt_d    = is_mul_op(op) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
                        res_hi_d = arith_hi;
                        res_lo_d = arith_lo;
                        keep_d   = arith_dz;
                        busy_d   = 1'b1;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_RUN: begin
                // busy stays high through the commit cycle; start is ignored here.
                busy_d = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (!keep_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            keep_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            keep_q   <= keep_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: 32-bit default instance plus an 8-bit, 1-cycle multiply instance.
module tb_md_unit;

    localparam logic [2:0] T_MULT  = 3'd0;
    localparam logic [2:0] T_MULTU = 3'd1;
    localparam logic [2:0] T_DIV   = 3'd2;
    localparam logic [2:0] T_DIVU  = 3'd3;
    localparam logic [2:0] T_MTHI  = 3'd4;
    localparam logic [2:0] T_MTLO  = 3'd5;
    localparam int MULN = 5;
    localparam int DIVN = 10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int checks;
    int failures;
    logic [31:0] m_hi, m_lo;

    md_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    md_unit #(.WIDTH(8), .MUL_CYCLES(1), .DIV_CYCLES(10)) dut8 (
        .clk(clk), .reset(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        logic        run_start;
        logic [2:0]  run_op;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op (called #1 after an edge, DUT idle), check busy/done timing,
    // that hi/lo hold during RUN, then the committed values.
    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                          input logic rs, input logic [2:0] ro);
        logic ok;
        int n;
        n = (o == T_MULT || o == T_MULTU) ? MULN : DIVN;
        start = 1'b1; op = o; a = av; b = bv;
        step();                                   // edge T
        start = rs; op = ro; a = ~av; b = bv + 32'd1;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (k > 0) step();
            if (busy !== 1'b1 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) ok = 1'b0;
        end
        step();                                   // edge T+N
        start = 1'b0;
        if (busy !== 1'b1 || done !== 1'b1) ok = 1'b0;
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        step();                                   // edge T+N+1
        if (busy !== 1'b0 || done !== 1'b0 || hi !== eh || lo !== el) ok = 1'b0;
        chk({nm, "_timing"}, 32'(ok), 32'd1);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic run8(input string nm, input logic [2:0] o, input logic [7:0] av,
                        input logic [7:0] bv, input int n, input logic [7:0] eh, input logic [7:0] el);
        logic ok;
        start8 = 1'b1; op8 = o; a8 = av; b8 = bv;
        step();
        start8 = 1'b0; a8 = ~av; b8 = ~bv;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (k > 0) step();
            if (busy8 !== 1'b1 || done8 !== 1'b0) ok = 1'b0;
        end
        step();
        if (busy8 !== 1'b1 || done8 !== 1'b1) ok = 1'b0;
        chk({nm, "_hi"}, 32'(hi8), 32'(eh));
        chk({nm, "_lo"}, 32'(lo8), 32'(el));
        step();
        if (busy8 !== 1'b0 || done8 !== 1'b0) ok = 1'b0;
        chk({nm, "_timing"}, 32'(ok), 32'd1);
    endtask

    initial begin
        logic ok;
        checks = 0; failures = 0;
        m_hi = 32'd0; m_lo = 32'd0;
        rst_n = 1'b0;
        start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        start8 = 1'b0; op8 = 3'd0; a8 = 8'd0; b8 = 8'd0;

        vecs[0]  = '{T_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, T_MULT};
        vecs[1]  = '{T_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, T_DIVU};
        vecs[2]  = '{T_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, T_DIVU};
        vecs[3]  = '{T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, T_MULT};
        vecs[4]  = '{T_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, T_MULT};
        vecs[5]  = '{T_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, T_MULT};
        vecs[6]  = '{T_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, T_MULT};
        vecs[7]  = '{T_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b1, T_MTHI};
        vecs[8]  = '{T_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, T_MULT};
        vecs[9]  = '{T_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, T_MULT};
        vecs[10] = '{T_MULT,  32'h00001000, 32'h00010000, 32'h00000000, 32'h10000000, 1'b1, T_MTLO};

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_hi8", 32'(hi8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].eh, vecs[i].el, vecs[i].run_start, vecs[i].run_op);
        end

        // MTHI in IDLE: visible after the edge, no busy
        start = 1'b1; op = T_MTHI; a = 32'hDEADBEEF;
        step();
        start = 1'b0;
        chk("mthi_hi", hi, 32'hDEADBEEF);
        chk("mthi_lo", lo, m_lo);
        chk("mthi_busy", 32'(busy), 32'd0);
        m_hi = 32'hDEADBEEF;

        // Preset HI/LO, then divide by zero keeps them
        start = 1'b1; op = T_MTHI; a = 32'h11;
        step();
        op = T_MTLO; a = 32'h22;
        step();
        start = 1'b0;
        chk("preset_hi", hi, 32'h11);
        chk("preset_lo", lo, 32'h22);
        m_hi = 32'h11; m_lo = 32'h22;
        run_op("div0", T_DIV, 32'h00000064, 32'h0, 32'h11, 32'h22, 1'b0, T_MULT);
        run_op("divu0", T_DIVU, 32'hFFFFFFFF, 32'h0, 32'h11, 32'h22, 1'b0, T_MULT);

        // Reset during RUN cycle 3 of a MULT: everything cleared, no done afterwards
        start = 1'b1; op = T_MULT; a = 32'd3; b = 32'd5;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #2;
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) ok = 1'b0;
        end
        chk("midrst_quiet", 32'(ok), 32'd1);
        m_hi = 32'd0; m_lo = 32'd0;

        // 8-bit instance, 1-cycle multiply
        run8("w8_mult", T_MULT, 8'h7F, 8'h7F, 1, 8'h3F, 8'h01);
        run8("w8_multu", T_MULTU, 8'hFF, 8'hFF, 1, 8'hFE, 8'h01);
        run8("w8_divovf", T_DIV, 8'h80, 8'hFF, DIVN, 8'h00, 8'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
